// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - functional-unit classes and scheduler defaults
package issue_scheduler_pkg;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MEM  = 2'd1,
    FU_MULT = 2'd2
  } FU_TYPE;

  localparam int NUM_RS_ENTRIES = 4;
  localparam int MULT_LATENCY   = 4;

endpackage

// File: rtl/issue_scheduler_age_matrix.sv
// rtl/issue_scheduler_age_matrix.sv - allocation-order matrix and oldest-request select
module age_matrix #(
  parameter  int NUM_ENTRIES = 4,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   alloc_valid,
  input  logic [IDX_W-1:0]       alloc_idx,
  input  logic [NUM_ENTRIES-1:0] req,
  output logic [NUM_ENTRIES-1:0] oldest
);

  // older[i][j]: entry i was allocated before entry j; the diagonal stays 0
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older;
  logic [NUM_ENTRIES-1:0]                  blocked;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          older[i][j] <= (i < j);
        end
      end
    end else if (alloc_valid && !flush) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (IDX_W'(j) != alloc_idx) begin
          older[alloc_idx][j] <= 1'b0;
          older[j][alloc_idx] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i) begin
          blocked[i] = blocked[i] | (req[j] & older[j][i]);
        end
      end
    end
    oldest = req & ~blocked;
  end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - age-ordered RS issue arbiter with memory and multiplier hazards
module issue_scheduler #(
  parameter  int NUM_ENTRIES  = issue_scheduler_pkg::NUM_RS_ENTRIES,
  parameter  int MULT_LATENCY = issue_scheduler_pkg::MULT_LATENCY,
  localparam int IDX_W        = $clog2(NUM_ENTRIES)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        alloc_valid,
  input  logic [IDX_W-1:0]            alloc_idx,
  input  logic [NUM_ENTRIES-1:0]      entry_ready,
  input  logic [NUM_ENTRIES-1:0][1:0] entry_fu,
  input  logic                        mem_done,
  input  logic                        ex_stall,
  output logic [NUM_ENTRIES-1:0]      grant,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        mem_busy,
  output logic                        mult_busy
);

  import issue_scheduler_pkg::*;

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);

  typedef enum logic {
    MEM_IDLE,
    MEM_BUSY
  } mem_state_e;

  mem_state_e             mem_state;
  logic [CNT_W-1:0]       mult_cnt;
  logic [NUM_ENTRIES-1:0] elig;
  logic [NUM_ENTRIES-1:0] is_mem;
  logic [NUM_ENTRIES-1:0] is_mult;
  logic                   grant_mem;
  logic                   grant_mult;

  assign mult_busy = (mult_cnt != '0);

  // Unknown FU encodings fall through as ALU: no structural hazard applies
  always_comb begin
    is_mem  = '0;
    is_mult = '0;
    elig    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      is_mem[i]  = (entry_fu[i] == FU_MEM);
      is_mult[i] = (entry_fu[i] == FU_MULT);
      elig[i]    = entry_ready[i] & ~ex_stall & ~flush & ~reset
                 & ~(is_mem[i] & mem_busy) & ~(is_mult[i] & mult_busy);
    end
  end

  age_matrix #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_age_matrix (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx),
    .req         (elig),
    .oldest      (grant)
  );

  assign grant_valid = |grant;
  assign grant_mem   = |(grant & is_mem);
  assign grant_mult  = |(grant & is_mult);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (grant[i]) begin
        grant_idx = grant_idx | IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      mem_state <= MEM_IDLE;
      mem_busy  <= 1'b0;
    end else begin
      case (mem_state)
        MEM_IDLE: begin
          if (grant_mem) begin
            mem_state <= MEM_BUSY;
            mem_busy  <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (mem_done) begin
            mem_state <= MEM_IDLE;
            mem_busy  <= 1'b0;
          end
        end
        default: begin
          mem_state <= MEM_IDLE;
          mem_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Loading LATENCY-1 leaves the unit free again exactly LATENCY cycles after a grant
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      mult_cnt <= '0;
    end else if (grant_mult) begin
      mult_cnt <= CNT_W'(MULT_LATENCY - 1);
    end else if (mult_cnt != '0) begin
      mult_cnt <= mult_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard bench for issue_scheduler
module tb_issue_scheduler;

  import issue_scheduler_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            alloc_valid;
  logic [1:0]      alloc_idx;
  logic [3:0]      entry_ready;
  logic [3:0][1:0] entry_fu;
  logic            mem_done;
  logic            ex_stall;
  logic [3:0]      grant;
  logic            grant_valid;
  logic [1:0]      grant_idx;
  logic            mem_busy;
  logic            mult_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic       mem;
    logic       mult;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  issue_scheduler #(
    .NUM_ENTRIES  (4),
    .MULT_LATENCY (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx),
    .entry_ready (entry_ready),
    .entry_fu    (entry_fu),
    .mem_done    (mem_done),
    .ex_stall    (ex_stall),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .mem_busy    (mem_busy),
    .mult_busy   (mult_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) r = i[1:0];
    end
    return r;
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle after inputs settle
  always @(negedge clock) begin
    if (alloc_valid === 1'b1 && reset === 1'b0) begin
      chk("alloc_rule", "ready_of_alloc", {31'd0, entry_ready[alloc_idx]}, 32'd0);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.nm, "grant",       {28'd0, grant},       {28'd0, e.g});
      chk(e.nm, "grant_idx",   {30'd0, grant_idx},   {30'd0, enc(e.g)});
      chk(e.nm, "grant_valid", {31'd0, grant_valid}, {31'd0, |e.g});
      chk(e.nm, "mem_busy",    {31'd0, mem_busy},    {31'd0, e.mem});
      chk(e.nm, "mult_busy",   {31'd0, mult_busy},   {31'd0, e.mult});
    end
  end

  task automatic cyc(input logic [3:0] rdy, input logic [3:0] eg, input logic em, input logic emu, input string nm);
    entry_ready = rdy;
    exp_q.push_back('{eg, em, emu, nm});
    @(posedge clock);
    #1;
    alloc_valid = 1'b0;
    flush       = 1'b0;
    mem_done    = 1'b0;
  endtask

  task automatic set_fu(input FU_TYPE f3, input FU_TYPE f2, input FU_TYPE f1, input FU_TYPE f0);
    entry_fu = {f3, f2, f1, f0};
  endtask

  task automatic alloc(input logic [1:0] k);
    alloc_valid = 1'b1;
    alloc_idx   = k;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_idx = 2'd0;
    entry_ready = 4'd0; entry_fu = '0; mem_done = 1'b0; ex_stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cyc(4'b1111, 4'b0000, 1'b0, 1'b0, "reset_hold");
    reset = 1'b0;

    // Age order: reset order 0,1,2,3 then alloc 2,0,3 -> 1,2,0,3
    set_fu(FU_ALU, FU_ALU, FU_ALU, FU_ALU);
    alloc(2'd2); cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "alloc2");
    alloc(2'd0); cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "alloc0");
    alloc(2'd3); cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "alloc3");
    cyc(4'b1101, 4'b0100, 1'b0, 1'b0, "age_first");
    cyc(4'b1001, 4'b0001, 1'b0, 1'b0, "age_second");
    cyc(4'b1000, 4'b1000, 1'b0, 1'b0, "age_third");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "age_idle");

    // Multiplier occupancy: entries 0,1 MULT; order becomes 3,0,1,2
    set_fu(FU_ALU, FU_ALU, FU_MULT, FU_MULT);
    alloc(2'd0); cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "m_alloc0");
    alloc(2'd1); cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "m_alloc1");
    alloc(2'd2); cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "m_alloc2");
    cyc(4'b0111, 4'b0001, 1'b0, 1'b0, "mult_first");
    cyc(4'b1110, 4'b1000, 1'b0, 1'b1, "mult_hold_alu3");
    alloc(2'd3); cyc(4'b0110, 4'b0100, 1'b0, 1'b1, "mult_hold_alu2");
    cyc(4'b1010, 4'b1000, 1'b0, 1'b1, "mult_hold_alu3b");
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, "mult_second");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1, "mult_busy_a");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1, "mult_busy_b");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1, "mult_busy_c");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "mult_free");

    // Memory hold: order is 0,1,2,3; entries 0,1 MEM
    set_fu(FU_ALU, FU_ALU, FU_MEM, FU_MEM);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0, "mem_first");
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0, "mem_hold_a");
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0, "mem_hold_b");
    mem_done = 1'b1;
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0, "mem_done_cycle");
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, "mem_second");
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, "mem_busy2");
    mem_done = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, "mem_done2");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "mem_idle");
    mem_done = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "mem_done_in_idle");
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0, "mem_after_idle_done");
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, "mem_busy3");
    mem_done = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, "mem_done3");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "mem_idle3");

    // Stall
    set_fu(FU_ALU, FU_ALU, FU_ALU, FU_ALU);
    ex_stall = 1'b1;
    cyc(4'b0110, 4'b0000, 1'b0, 1'b0, "stall_a");
    cyc(4'b0110, 4'b0000, 1'b0, 1'b0, "stall_b");
    cyc(4'b0110, 4'b0000, 1'b0, 1'b0, "stall_c");
    ex_stall = 1'b0;
    cyc(4'b0110, 4'b0010, 1'b0, 1'b0, "stall_release");
    cyc(4'b0100, 4'b0100, 1'b0, 1'b0, "stall_next");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "stall_idle");

    // Flush mid-operation
    set_fu(FU_ALU, FU_MEM, FU_MULT, FU_MULT);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0, "flush_mult_grant");
    flush = 1'b1;
    cyc(4'b0010, 4'b0000, 1'b0, 1'b1, "flush_cycle");
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, "flush_mult_regrant");
    cyc(4'b0100, 4'b0100, 1'b0, 1'b1, "flush_mem_grant");
    flush = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b1, 1'b1, "flush2_cycle");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "flush2_after");
    set_fu(FU_ALU, FU_ALU, FU_ALU, FU_ALU);
    flush = 1'b1;
    alloc(2'd0);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "flush_alloc");
    cyc(4'b0011, 4'b0001, 1'b0, 1'b0, "flush_kept_order");

    // Allocation/grant collision: order 0,1,2,3 -> alloc 1 -> 0,2,3,1
    alloc(2'd1);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0, "collide_grant_old");
    cyc(4'b0110, 4'b0100, 1'b0, 1'b0, "collide_new_order");
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, "collide_young");
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, "collide_idle");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Age-ordered issue arbiter for the reservation-station bank. Each cycle it picks, from up to `NUM_ENTRIES` RS entries whose operands are ready, the oldest one whose functional unit can accept it, and returns a one-hot grant that the RS bank uses to select the issue packet and clear the entry's ready bits. It tracks two structural hazards:
- occupancy of the non-pipelined memory unit;
- occupancy of the non-pipelined multiplier.

It sits between the RS entries and the RS→EX issue register.

## Interface
Parameters:
- `NUM_ENTRIES`, 4, number of RS entries arbitrated (≥2).
- `MULT_LATENCY`, 4, multiplier occupancy in cycles per operation (≥1).

Ports:
- `clock`  in  1  system clock; everything is posedge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  branch mispredict (the CDB `take_branch`); squashes all state.
- `alloc_valid`  in  1  an entry is being written by dispatch this cycle.
- `alloc_idx`  in  `$clog2(NUM_ENTRIES)`  index of the entry being allocated.
- `entry_ready`  in  `NUM_ENTRIES`  per entry: busy, and both operands ready.
- `entry_fu`  in  `NUM_ENTRIES`×2  per-entry FU class: `FU_ALU`=0, `FU_MEM`=1, `FU_MULT`=2.
- `mem_done`  in  1  one-cycle pulse; the memory unit has finished its operation.
- `ex_stall`  in  1  the issue register cannot accept a packet this cycle.
- `grant`  out  `NUM_ENTRIES`  one-hot issue select; all zeros means no issue.
- `grant_valid`  out  1  OR of `grant`.
- `grant_idx`  out  `$clog2(NUM_ENTRIES)`  encoded `grant`; 0 when `grant_valid`=0.
- `mem_busy`  out  1  the memory unit is occupied.
- `mult_busy`  out  1  the multiplier counter is nonzero.

## Operation
- **Age matrix.** `older[i][j]`=1 means entry i was allocated before entry j. Only the off-diagonal bits are stored.
- **Allocation.** On `alloc_valid` with index k:
  - `older[k][*]` <= 0 (k becomes the youngest);
  - `older[*][k]` <= 1 for every j≠k.
- **Eligibility.** `elig[i] = entry_ready[i] & !ex_stall & !flush & !reset` and:
  - for `FU_MEM`: `!mem_busy`;
  - for `FU_MULT`: `mult_cnt==0`;
  - for `FU_ALU`: no extra condition.
- **Grant.** `grant[i] = elig[i] & ~|(elig[j] & older[j][i])` over all j≠i. This produces exactly one hot bit whenever any entry is eligible. `grant` is combinational from registered state plus inputs.
- **Memory FSM.** States are IDLE and BUSY.
  - IDLE→BUSY when a `FU_MEM` entry is granted.
  - BUSY→IDLE on `mem_done`.
  - A `mem_done` seen while in IDLE is ignored.
- **Multiplier counter.** `mult_cnt` is `$clog2(MULT_LATENCY+1)` bits wide.
  - Loads `MULT_LATENCY-1` when a `FU_MULT` entry is granted.
  - Otherwise decrements while nonzero, saturating at 0.
- **Flush.** Forces `grant` to 0 in the same cycle. Next cycle: `mem_busy`=0 and `mult_cnt`=0. The age matrix is kept unchanged, because stale order among freed entries is harmless.
- **Reset values.** `older[i][j]` = (i<j); `mem_busy`=0; `mult_cnt`=0; `grant`=0, `grant_valid`=0, `grant_idx`=0.
- **Reset vs. other inputs.** Reset has priority over flush, and flush has priority over allocation.

## Timing
- Grant has zero latency. Entry i, when eligible in cycle t, is granted in cycle t. The RS bank clears its ready bits at edge t+1.
- `mem_busy` rises at edge t+1 after a mem grant at t. It falls at the edge following the `mem_done` cycle. No mem grant is allowed in the `mem_done` cycle itself.
- Multiplier: after a mult grant at cycle t, the next mult grant can occur no earlier than cycle t+`MULT_LATENCY`. With `MULT_LATENCY`=1, mult grants can issue back-to-back.
- `ex_stall`=1 suppresses every grant; state is unchanged except for `mult_cnt` decrementing and `mem_done` being processed.
- Allocation of k in cycle t takes effect at edge t+1. A grant in the same cycle uses the old order.
- Allocating an index that is currently eligible is illegal; the bench asserts this never happens.

## Structure
- Shared package (the existing `sys_defs` style):
  - `FU_TYPE` enum (`FU_ALU`, `FU_MEM`, `FU_MULT`);
  - the `NUM_RS_ENTRIES` and `MULT_LATENCY` defaults.
- Sub-module `age_matrix`:
  - contents: matrix storage, allocation update, and the oldest-of-request-vector select;
  - parameter: `NUM_ENTRIES`;
  - inputs: `req` vector; output: one-hot `oldest`.
- The FU hazard logic and `grant_idx` encoding live in `issue_scheduler`.

## Test plan
- **Reset, then age order.** Allocate entries 2, 0, 3 in that order, all ALU, and raise all three `entry_ready` together → grant 2, 0, 3 in successive cycles as each ready bit drops; `grant_idx` reads 2, 0, 3.
- **Multiplier occupancy.** Two ready MULT entries with `MULT_LATENCY`=4; first granted at cycle 10 → second granted at cycle 14. A ready ALU entry is granted in cycles 11–13.
- **Memory hold.** A mem entry is granted, then another mem entry becomes ready → held while `mem_busy`=1; `mem_done` pulses at cycle 20 → second mem grant at cycle 21.
- **Stall.** `ex_stall`=1 for 3 cycles with 2 ready entries → `grant`=0 throughout; the oldest entry is granted in the first cycle `ex_stall`=0.
- **Flush mid-operation.** Mult grant, then `flush` 1 cycle later → `grant`=0 in the flush cycle; `mult_busy`=0 and `mem_busy`=0 at the next edge; a new mult grant is possible immediately after.
- **Allocation/grant collision.** Entry 1 is allocated while entry 0 is granted in the same cycle → the grant goes to 0. Next cycle, with both ready, the older entry wins per the updated matrix.
